// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM gate datapath: FSM encoding, default
// Q-format and the shift-and-saturate helper used when results leave the accumulator.
package lstm_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Arithmetic shift (floor) then clamp to a signed width-bit range.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int width);
        logic signed [63:0] shifted;
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        shifted = acc >>> frac;
        max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (width - 1));
        if (shifted > max_val) return max_val;
        if (shifted < min_val) return min_val;
        return shifted;
    endfunction

endpackage

// File: rtl/mac_sat_unit.sv
// Product register, row accumulator and saturating output register.
// Row-first/row-last flags arrive alongside the operands and travel with the product.
module mac_sat_unit
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = 40,
    parameter int ROW_WIDTH  = 5
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [ROW_WIDTH-1:0]  in_row,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  prod_valid,
    output logic                  result_valid,
    output logic [ROW_WIDTH-1:0]  result_index,
    output logic [DATA_WIDTH-1:0] result_data
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic                           prod_first;
    logic                           prod_last;
    logic [ROW_WIDTH-1:0]           prod_row;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_next;

    always_comb begin
        prod_ext = ACC_WIDTH'(prod);
        acc_next = prod_first ? prod_ext : acc + prod_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_valid   <= 1'b0;
            prod         <= '0;
            prod_first   <= 1'b0;
            prod_last    <= 1'b0;
            prod_row     <= '0;
            acc          <= '0;
            result_valid <= 1'b0;
            result_index <= '0;
            result_data  <= '0;
        end else begin
            prod_valid   <= in_valid;
            result_valid <= prod_valid && prod_last;
            if (in_valid) begin
                prod       <= (2*DATA_WIDTH)'($signed(w_data)) * (2*DATA_WIDTH)'($signed(x_data));
                prod_first <= in_first;
                prod_last  <= in_last;
                prod_row   <= in_row;
            end
            if (prod_valid) acc <= acc_next;
            // Output register takes the final sum directly so it lands with result_valid.
            if (prod_valid && prod_last) begin
                result_data  <= DATA_WIDTH'(sat_shift(64'(acc_next), FRAC_BITS, DATA_WIDTH));
                result_index <= prod_row;
            end
        end
    end

endmodule

// File: rtl/ih_gate_matvec.sv
// Input-hidden matrix-vector product for one LSTM gate: streams weights row-major
// from the gate weight memory, x from the x buffer, and emits one saturated result per row.
module ih_gate_matvec
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FRAC_BITS    = DEF_FRAC_BITS,
    parameter int ADDR_WIDTH   = 10,
    parameter int X_ADDR_WIDTH = 5,
    parameter int INPUT_SIZE   = 30,
    parameter int HIDDEN_SIZE  = 20,
    parameter int ACC_WIDTH    = 40,
    localparam int ROW_WIDTH   = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    w_read_enable,
    output logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic                    x_read_enable,
    output logic [X_ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0]   x_data,
    output logic                    result_valid,
    output logic [ROW_WIDTH-1:0]    result_index,
    output logic [DATA_WIDTH-1:0]   result_data
);

    state_t                  state;
    state_t                  state_next;
    logic [ROW_WIDTH-1:0]    row;
    logic [X_ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    col_last;
    logic                    row_last;
    logic                    op_valid;
    logic                    op_first;
    logic                    op_last;
    logic [ROW_WIDTH-1:0]    op_row;
    logic                    prod_valid;

    assign col_last = (col == X_ADDR_WIDTH'(INPUT_SIZE - 1));
    assign row_last = (row == ROW_WIDTH'(HIDDEN_SIZE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        w_read_enable = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_read_enable = 1'b1;
                busy          = 1'b1;
                if (row_last && col_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Empty once neither the operand nor the product stage holds data.
                if (!op_valid && !prod_valid) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign x_read_enable = w_read_enable;
    assign w_addr        = addr;
    assign x_addr        = col;

    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_IDLE) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (state == ST_FETCH) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (col_last) begin
                col <= '0;
                row <= row + ROW_WIDTH'(1);
            end else begin
                col <= col + X_ADDR_WIDTH'(1);
            end
        end
    end

    // Flags for the address issued this cycle, aligned with the 1-cycle memory latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_first <= 1'b0;
            op_last  <= 1'b0;
            op_row   <= '0;
        end else begin
            op_valid <= (state == ST_FETCH);
            op_first <= (col == '0);
            op_last  <= col_last;
            op_row   <= row;
        end
    end

    mac_sat_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH),
        .ROW_WIDTH  (ROW_WIDTH)
    ) u_mac (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (op_valid),
        .in_first     (op_first),
        .in_last      (op_last),
        .in_row       (op_row),
        .w_data       (w_data),
        .x_data       (x_data),
        .prod_valid   (prod_valid),
        .result_valid (result_valid),
        .result_index (result_index),
        .result_data  (result_data)
    );

endmodule

// File: tb/tb_ih_gate_matvec.sv
// Bench for ih_gate_matvec: a 2x3 instance and a default 20x30 instance, each fed by
// behavioural weight/x memories, with a per-instance queue of expected row results.
module tb_ih_gate_matvec;

    typedef struct {
        int          idx;
        logic [15:0] data;
        int          rel;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Small instance: 3 columns, 2 rows
    logic        s_rst_n = 1'b0, s_start = 1'b0;
    logic        s_busy, s_done, s_w_re, s_x_re, s_result_valid;
    logic [9:0]  s_w_addr;
    logic [4:0]  s_x_addr;
    logic [15:0] s_w_data = '0, s_x_data = '0, s_result_data;
    logic [0:0]  s_result_index;
    logic [15:0] s_wmem [0:1023];
    logic [15:0] s_xmem [0:31];
    exp_t        s_q [$];
    int          s_base = 0;

    // Default instance: 30 columns, 20 rows
    logic        d_rst_n = 1'b0, d_start = 1'b0;
    logic        d_busy, d_done, d_w_re, d_x_re, d_result_valid;
    logic [9:0]  d_w_addr;
    logic [4:0]  d_x_addr;
    logic [15:0] d_w_data = '0, d_x_data = '0, d_result_data;
    logic [4:0]  d_result_index;
    logic [15:0] d_wmem [0:1023];
    logic [15:0] d_xmem [0:31];
    exp_t        d_q [$];
    int          d_base = 0;

    ih_gate_matvec #(.INPUT_SIZE(3), .HIDDEN_SIZE(2), .FRAC_BITS(8)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .w_read_enable(s_w_re), .w_addr(s_w_addr), .w_data(s_w_data),
        .x_read_enable(s_x_re), .x_addr(s_x_addr), .x_data(s_x_data),
        .result_valid(s_result_valid), .result_index(s_result_index), .result_data(s_result_data)
    );

    ih_gate_matvec dut (
        .clk(clk), .rst_n(d_rst_n), .start(d_start), .busy(d_busy), .done(d_done),
        .w_read_enable(d_w_re), .w_addr(d_w_addr), .w_data(d_w_data),
        .x_read_enable(d_x_re), .x_addr(d_x_addr), .x_data(d_x_data),
        .result_valid(d_result_valid), .result_index(d_result_index), .result_data(d_result_data)
    );

    always @(posedge clk) begin
        if (s_w_re) s_w_data <= s_wmem[s_w_addr];
        if (s_x_re) s_x_data <= s_xmem[s_x_addr];
        if (d_w_re) d_w_data <= d_wmem[d_w_addr];
        if (d_x_re) d_x_data <= d_xmem[d_x_addr];
    end

    function automatic exp_t mk_exp(input int r, input longint sum, input int cols);
        exp_t   e;
        longint s;
        s = sum >>> 8;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        e.idx  = r;
        e.data = 16'(s);
        e.rel  = (r + 1) * cols + 3;
        return e;
    endfunction

    function automatic void push_exp(input bit dflt);
        int     rows, cols;
        longint sum;
        rows = dflt ? 20 : 2;
        cols = dflt ? 30 : 3;
        for (int r = 0; r < rows; r++) begin
            sum = 0;
            for (int c = 0; c < cols; c++) begin
                if (dflt) sum += longint'($signed(d_wmem[r*cols+c])) * longint'($signed(d_xmem[c]));
                else      sum += longint'($signed(s_wmem[r*cols+c])) * longint'($signed(s_xmem[c]));
            end
            if (dflt) d_q.push_back(mk_exp(r, sum, cols));
            else      s_q.push_back(mk_exp(r, sum, cols));
        end
    endfunction

    // Result monitors: pop expected row, compare index, data and arrival cycle
    always @(negedge clk) begin
        exp_t e;
        if (s_result_valid) begin
            if (s_q.size() == 0) chk("s_unexpected_result", 1, 0);
            else begin
                e = s_q.pop_front();
                chk("s_index", s_result_index, e.idx);
                chk("s_data", s_result_data, e.data);
                chk("s_time", cyc - s_base, e.rel);
            end
        end
        if (d_result_valid) begin
            if (d_q.size() == 0) chk("d_unexpected_result", 1, 0);
            else begin
                e = d_q.pop_front();
                chk("d_index", d_result_index, e.idx);
                chk("d_data", d_result_data, e.data);
                chk("d_time", cyc - d_base, e.rel);
            end
        end
    end

    // Address-stream tracking on the default instance
    int exp_a = 0, n_rd = 0, addr_bad = 0, first_rd = 0, last_rd = 0;
    always @(negedge clk) begin
        if (d_x_re != d_w_re) addr_bad++;
        if (d_w_re) begin
            if (d_w_addr != 10'(exp_a) || d_x_addr != 5'(exp_a % 30)) addr_bad++;
            if (n_rd == 0) first_rd = cyc;
            last_rd = cyc;
            n_rd++;
            exp_a++;
        end
    end

    task automatic run_s();
        bit seen_done;
        int rel;
        push_exp(1'b0);
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0; s_base = cyc - 1;
        chk("s_busy_after_start", s_busy, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            @(negedge clk);
            rel = cyc - s_base;
            if (s_done) begin
                chk("s_done_time", rel, 10);
                chk("s_busy_at_done", s_busy, 0);
                seen_done = 1'b1;
            end
        end
        if (!seen_done) chk("s_done_timeout", 0, 1);
        chk("s_queue_empty", s_q.size(), 0);
    endtask

    task automatic run_d(input int busy_start_at, input int rst_at);
        bit seen_done;
        int rel, quiet;
        exp_a = 0; n_rd = 0; addr_bad = 0;
        push_exp(1'b1);
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0; d_base = cyc - 1;
        chk("d_busy_after_start", d_busy, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 800 && !seen_done; i++) begin
            @(negedge clk);
            rel = cyc - d_base;
            d_start = (rel == busy_start_at);
            if (rst_at > 0 && rel == rst_at) begin
                d_rst_n = 1'b0;
                d_q.delete();
                @(negedge clk);
                chk("d_reset_midop_outputs",
                    {d_w_re, d_w_addr, d_x_re, d_x_addr, d_result_valid,
                     d_result_index, d_result_data, d_busy, d_done}, 0);
                d_rst_n = 1'b1;
                quiet = 0;
                for (int k = 0; k < 700; k++) begin
                    @(negedge clk);
                    if (d_result_valid || d_done || d_busy) quiet++;
                end
                chk("d_abort_quiet", quiet, 0);
                return;
            end
            if (d_done) begin
                chk("d_done_time", rel, 604);
                chk("d_busy_at_done", d_busy, 0);
                seen_done = 1'b1;
            end
        end
        d_start = 1'b0;
        if (!seen_done) chk("d_done_timeout", 0, 1);
        chk("d_queue_empty", d_q.size(), 0);
        chk("d_addr_seq", addr_bad, 0);
        chk("d_read_count", n_rd, 600);
        chk("d_read_span", last_rd - first_rd + 1, 600);
        chk("d_first_read", first_rd - d_base, 1);
    endtask

    task automatic fill_d(input int mode);
        for (int i = 0; i < 600; i++) begin
            case (mode)
                1:       d_wmem[i] = 16'h7FFF;
                2:       d_wmem[i] = 16'h8000;
                default: d_wmem[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
            endcase
        end
        for (int c = 0; c < 30; c++)
            d_xmem[c] = (mode == 0) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'h7FFF;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin s_wmem[i] = '0; d_wmem[i] = '0; end
        for (int i = 0; i < 32; i++)   begin s_xmem[i] = '0; d_xmem[i] = '0; end
        repeat (3) @(negedge clk);
        chk("s_reset_outputs", {s_w_re, s_w_addr, s_x_re, s_x_addr, s_result_valid,
                                s_result_index, s_result_data, s_busy, s_done}, 0);
        chk("d_reset_outputs", {d_w_re, d_w_addr, d_x_re, d_x_addr, d_result_valid,
                                d_result_index, d_result_data, d_busy, d_done}, 0);
        s_rst_n = 1'b1;
        d_rst_n = 1'b1;

        // W = [[1,2,-1],[0.5,0.5,0.5]], x = [1,1,2] -> 0x0100, 0x0200
        s_wmem[0] = 16'h0100; s_wmem[1] = 16'h0200; s_wmem[2] = 16'hFF00;
        s_wmem[3] = 16'h0080; s_wmem[4] = 16'h0080; s_wmem[5] = 16'h0080;
        s_xmem[0] = 16'h0100; s_xmem[1] = 16'h0100; s_xmem[2] = 16'h0200;
        run_s();

        // Row 0 sums to -1 LSB of the Q16.16 accumulator -> floor gives 0xFFFF
        s_wmem[0] = 16'hFFFF; s_wmem[1] = 16'h0000; s_wmem[2] = 16'h0000;
        s_wmem[3] = 16'h0300; s_wmem[4] = 16'hFE80; s_wmem[5] = 16'h0041;
        s_xmem[0] = 16'h0001; s_xmem[1] = 16'h0000; s_xmem[2] = 16'h0000;
        run_s();
        s_xmem[1] = 16'h0123; s_xmem[2] = 16'hFF77;
        s_wmem[0] = 16'h0000;
        run_s();

        fill_d(0); run_d(0, 0);
        fill_d(1); run_d(0, 0);
        fill_d(2); run_d(0, 0);
        fill_d(0); run_d(5, 0);
        fill_d(0); run_d(0, 0);
        fill_d(0); run_d(0, 50);
        fill_d(0); run_d(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
